store_load_unit: RTL and testbench

Single-clock store buffer and load unit between the CPU data-memory interface and the memory's write port and second read port. This is the data-side counterpart of the instruction fetch path. It queues CPU stores in an in-order buffer and drains them to memory under a valid/ready handshake. It services CPU loads either by forwarding from the youngest matching buffered store or by a read on memory read port 2.

---
 rtl/store_load_unit.sv | 171 +++++++++++++++++
 tb/tb_store_load_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_load_unit.sv
// Data-side store buffer and load unit: queues CPU stores in order, drains them
// to the memory write port, and serves loads by store forwarding or a port-2 read.
module store_load_unit #(
    parameter int DATA_SIZE = 32,
    parameter int ADRS_SIZE = 11,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         write_mem,
    input  logic [ADRS_SIZE-1:0]         mem_wadrs,
    input  logic [DATA_SIZE-1:0]         mem_wdata,
    output logic                         store_stall,
    input  logic                         read_mem_str,
    input  logic [ADRS_SIZE-1:0]         mem_radrs_ld,
    output logic                         load_stall,
    output logic [DATA_SIZE-1:0]         mem_store_data,
    output logic                         load_valid,
    output logic                         mem_w_en,
    input  logic                         mem_w_ready,
    output logic [ADRS_SIZE-1:0]         mem_w_adrs,
    output logic [DATA_SIZE-1:0]         mem_w_data,
    output logic                         mem_r_en2,
    output logic [ADRS_SIZE-1:0]         mem_r_adrs2,
    input  logic                         mem_r_valid2,
    input  logic [DATA_SIZE-1:0]         mem_data_out2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [ADRS_SIZE-1:0] r_adrs [DEPTH];
    logic [DATA_SIZE-1:0] r_data [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_SIZE-1:0] r_ld_data;
    logic                 r_ld_valid;
    logic [ADRS_SIZE-1:0] r_rd_adrs;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ld_accept;
    logic                 w_hit;
    logic                 w_match;
    logic [DATA_SIZE-1:0] w_hit_data;

    assign w_full         = (r_count == CW'(DEPTH));
    assign store_stall    = w_full;
    assign mem_w_en       = (r_count != {CW{1'b0}});
    assign mem_w_adrs     = r_adrs[r_head];
    assign mem_w_data     = r_data[r_head];
    assign count          = r_count;
    assign w_push         = write_mem && !w_full;
    assign w_pop          = mem_w_en && mem_w_ready;
    assign w_ld_accept    = (r_state == S_IDLE) && read_mem_str && !load_stall;
    assign mem_store_data = r_ld_data;
    assign load_valid     = r_ld_valid;
    assign mem_r_adrs2    = r_rd_adrs;

    // Forwarding lookup: walk oldest to youngest so the youngest match wins
    always_comb begin
        w_hit      = 1'b0;
        w_match    = 1'b0;
        w_hit_data = {DATA_SIZE{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            w_match    = (CW'(k) < r_count) &&
                         (r_adrs[r_head + PW'(k)] == mem_radrs_ld);
            w_hit      = w_hit | w_match;
            w_hit_data = w_match ? r_data[r_head + PW'(k)] : w_hit_data;
        end
    end

    // Store buffer storage, written at the tail on push
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_adrs[i] <= {ADRS_SIZE{1'b0}};
                r_data[i] <= {DATA_SIZE{1'b0}};
            end
        end else if (w_push) begin
            r_adrs[r_tail] <= mem_wadrs;
            r_data[r_tail] <= mem_wdata;
        end
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) r_tail <= r_tail + {{(PW-1){1'b0}}, 1'b1};
            if (w_pop)  r_head <= r_head + {{(PW-1){1'b0}}, 1'b1};
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Load FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Load FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ld_accept && !w_hit) w_state_nxt = S_ISSUE;
                else                       w_state_nxt = S_IDLE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_r_valid2) w_state_nxt = S_IDLE;
                else              w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Load FSM outputs; a same-cycle store takes priority over a load
    always_comb begin
        mem_r_en2  = 1'b0;
        load_stall = 1'b0;
        case (r_state)
            S_IDLE:  load_stall = write_mem;
            S_ISSUE: begin
                mem_r_en2  = 1'b1;
                load_stall = 1'b1;
            end
            S_WAIT:  load_stall = 1'b1;
            default: load_stall = 1'b1;
        endcase
    end

    // Load result, completion pulse and latched miss address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ld_data  <= {DATA_SIZE{1'b0}};
            r_ld_valid <= 1'b0;
            r_rd_adrs  <= {ADRS_SIZE{1'b0}};
        end else begin
            r_ld_valid <= 1'b0;
            if (w_ld_accept && w_hit) begin
                r_ld_data  <= w_hit_data;
                r_ld_valid <= 1'b1;
            end else if ((r_state == S_WAIT) && mem_r_valid2) begin
                r_ld_data  <= mem_data_out2;
                r_ld_valid <= 1'b1;
            end
            if (w_ld_accept && !w_hit) r_rd_adrs <= mem_radrs_ld;
        end
    end

endmodule

// File: tb/tb_store_load_unit.sv
// Directed self-checking bench for store_load_unit: one task per scenario,
// inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_store_load_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        write_mem = 1'b0;
    logic [10:0] mem_wadrs = 11'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        store_stall;
    logic        read_mem_str = 1'b0;
    logic [10:0] mem_radrs_ld = 11'd0;
    logic        load_stall;
    logic [31:0] mem_store_data;
    logic        load_valid;
    logic        mem_w_en;
    logic        mem_w_ready = 1'b0;
    logic [10:0] mem_w_adrs;
    logic [31:0] mem_w_data;
    logic        mem_r_en2;
    logic [10:0] mem_r_adrs2;
    logic        mem_r_valid2;
    logic [31:0] mem_data_out2;
    logic [2:0]  count;

    logic        model_en = 1'b0;
    logic        model_valid = 1'b0;
    logic        tb_valid = 1'b0;
    logic [31:0] mem_word = 32'd0;

    int errors = 0;
    int checks = 0;

    store_load_unit #(.DATA_SIZE(32), .ADRS_SIZE(11), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .write_mem(write_mem), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
        .store_stall(store_stall),
        .read_mem_str(read_mem_str), .mem_radrs_ld(mem_radrs_ld),
        .load_stall(load_stall), .mem_store_data(mem_store_data), .load_valid(load_valid),
        .mem_w_en(mem_w_en), .mem_w_ready(mem_w_ready),
        .mem_w_adrs(mem_w_adrs), .mem_w_data(mem_w_data),
        .mem_r_en2(mem_r_en2), .mem_r_adrs2(mem_r_adrs2),
        .mem_r_valid2(mem_r_valid2), .mem_data_out2(mem_data_out2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Memory port 2: one cycle read latency when enabled
    always @(posedge clk) model_valid <= mem_r_en2 & model_en;
    assign mem_r_valid2  = model_valid | tb_valid;
    assign mem_data_out2 = mem_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; write_mem = 1'b1; read_mem_str = 1'b1; mem_radrs_ld = 11'd5;
        tick(); tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (store_stall !== 1'b0) begin errors++; $display("FAIL rst_store_stall: got %0b expected 0", store_stall); end
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en: got %0b expected 0", mem_w_en); end
        checks++; if ({mem_w_adrs, mem_w_data} !== 43'd0) begin errors++; $display("FAIL rst_w_head: got %0h expected 0", {mem_w_adrs, mem_w_data}); end
        checks++; if ({load_valid, mem_r_en2} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %0b expected 0", {load_valid, mem_r_en2}); end
        checks++; if ({mem_store_data, mem_r_adrs2} !== 43'd0) begin errors++; $display("FAIL rst_ld_regs: got %0h expected 0", {mem_store_data, mem_r_adrs2}); end
        write_mem = 1'b0;
        #1;
        checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL rst_idle: got load_stall %0b expected 0", load_stall); end
        read_mem_str = 1'b0;
        resetn = 1'b1;
        tick();
        checks++; if ({count, store_stall, mem_w_en} !== 5'd0) begin errors++; $display("FAIL rst_release: got %0h expected 0", {count, store_stall, mem_w_en}); end
    endtask

    task automatic test_store_full();
        mem_w_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            write_mem = 1'b1; mem_wadrs = 11'(i); mem_wdata = 32'hA0 + 32'(i);
            tick();
        end
        write_mem = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (store_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b expected 1", store_stall); end
        checks++; if (mem_w_adrs !== 11'd1 || mem_w_data !== 32'hA1) begin errors++; $display("FAIL full_head: got %0h/%0h expected 1/a1", mem_w_adrs, mem_w_data); end
        mem_w_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (mem_w_en !== 1'b1 || mem_w_adrs !== 11'(i) || mem_w_data !== 32'hA0 + 32'(i))
                begin errors++; $display("FAIL drain_%0d: got %0b/%0h/%0h expected 1/%0h/%0h", i, mem_w_en, mem_w_adrs, mem_w_data, i, 32'hA0 + 32'(i)); end
            tick();
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count_%0d: got %0d expected %0d", i, count, 4 - i); end
        end
        mem_w_ready = 1'b0;
        checks++; if (mem_w_en !== 1'b0 || store_stall !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b/%0b expected 0/0", mem_w_en, store_stall); end
        write_mem = 1'b1; mem_wadrs = 11'd2; mem_wdata = 32'hB1;
        tick();
        write_mem = 1'b0;
        checks++; if (mem_w_en !== 1'b1 || mem_w_data !== 32'hB1 || count !== 3'd1) begin errors++; $display("FAIL wrap_head: got %0b/%0h/%0d expected 1/b1/1", mem_w_en, mem_w_data, count); end
        mem_w_ready = 1'b1;
        tick();
        mem_w_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_pop: got %0d expected 0", count); end
    endtask

    task automatic test_forward();
        logic [31:0] vals [3];
        logic [10:0] adrs [3];
        vals = '{32'h11, 32'h22, 32'h33};
        adrs = '{11'd7, 11'd7, 11'd9};
        mem_w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_mem = 1'b1; mem_wadrs = adrs[i]; mem_wdata = vals[i];
            tick();
        end
        write_mem = 1'b0; read_mem_str = 1'b1; mem_radrs_ld = 11'd7;
        tick();
        read_mem_str = 1'b0;
        checks++; if (load_valid !== 1'b1 || mem_store_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest: got %0b/%0h expected 1/22", load_valid, mem_store_data); end
        checks++; if (mem_r_en2 !== 1'b0) begin errors++; $display("FAIL fwd_no_read_a: got %0b expected 0", mem_r_en2); end
        tick();
        checks++; if (load_valid !== 1'b0 || mem_store_data !== 32'h22) begin errors++; $display("FAIL fwd_pulse_hold: got %0b/%0h expected 0/22", load_valid, mem_store_data); end
        checks++; if (mem_r_en2 !== 1'b0) begin errors++; $display("FAIL fwd_no_read_b: got %0b expected 0", mem_r_en2); end
        mem_w_ready = 1'b1;
        tick(); tick(); tick();
        mem_w_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fwd_drain: got %0d expected 0", count); end
    endtask

    task automatic test_miss();
        model_en = 1'b1; mem_word = 32'hDEADBEEF;
        read_mem_str = 1'b1; mem_radrs_ld = 11'h3F;
        tick();
        read_mem_str = 1'b0;
        checks++; if (mem_r_en2 !== 1'b1 || mem_r_adrs2 !== 11'h3F) begin errors++; $display("FAIL miss_issue: got %0b/%0h expected 1/3f", mem_r_en2, mem_r_adrs2); end
        checks++; if (load_stall !== 1'b1 || load_valid !== 1'b0) begin errors++; $display("FAIL miss_n1_stall: got %0b/%0b expected 1/0", load_stall, load_valid); end
        tick();
        checks++; if (mem_r_en2 !== 1'b0 || load_stall !== 1'b1 || load_valid !== 1'b0) begin errors++; $display("FAIL miss_n2: got %0b/%0b/%0b expected 0/1/0", mem_r_en2, load_stall, load_valid); end
        tick();
        checks++; if (load_valid !== 1'b1 || mem_store_data !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data: got %0b/%0h expected 1/deadbeef", load_valid, mem_store_data); end
        checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL miss_idle: got %0b expected 0", load_stall); end
        tick();
        checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL miss_pulse: got %0b expected 0", load_valid); end
        model_en = 1'b0;
    endtask

    task automatic test_store_and_load();
        mem_w_ready = 1'b0;
        write_mem = 1'b1; mem_wadrs = 11'h20; mem_wdata = 32'h55;
        read_mem_str = 1'b1; mem_radrs_ld = 11'h20;
        #1;
        checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL sl_priority: got %0b expected 1", load_stall); end
        tick();
        write_mem = 1'b0;
        checks++; if (count !== 3'd1 || load_valid !== 1'b0 || mem_r_en2 !== 1'b0) begin errors++; $display("FAIL sl_held: got %0d/%0b/%0b expected 1/0/0", count, load_valid, mem_r_en2); end
        tick();
        read_mem_str = 1'b0;
        checks++; if (load_valid !== 1'b1 || mem_store_data !== 32'h55) begin errors++; $display("FAIL sl_fwd: got %0b/%0h expected 1/55", load_valid, mem_store_data); end
        read_mem_str = 1'b1; mem_radrs_ld = 11'h40;
        tick();
        read_mem_str = 1'b0;
        checks++; if (mem_r_en2 !== 1'b1 || mem_r_adrs2 !== 11'h40) begin errors++; $display("FAIL sl_issue: got %0b/%0h expected 1/40", mem_r_en2, mem_r_adrs2); end
        tick();
        write_mem = 1'b1; mem_wadrs = 11'h21; mem_wdata = 32'h66;
        tick();
        write_mem = 1'b0;
        checks++; if (count !== 3'd2 || load_stall !== 1'b1) begin errors++; $display("FAIL sl_wait_store: got %0d/%0b expected 2/1", count, load_stall); end
        mem_word = 32'h77; tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
        checks++; if (load_valid !== 1'b1 || mem_store_data !== 32'h77) begin errors++; $display("FAIL sl_wait_done: got %0b/%0h expected 1/77", load_valid, mem_store_data); end
        mem_w_ready = 1'b1;
        tick(); tick();
        mem_w_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sl_drain: got %0d expected 0", count); end
    endtask

    task automatic test_reset_wait();
        read_mem_str = 1'b1; mem_radrs_ld = 11'h50;
        tick();
        read_mem_str = 1'b0;
        tick();
        write_mem = 1'b1; mem_wadrs = 11'd3; mem_wdata = 32'h99;
        tick();
        write_mem = 1'b0;
        checks++; if (count !== 3'd1 || load_stall !== 1'b1) begin errors++; $display("FAIL rw_pre: got %0d/%0b expected 1/1", count, load_stall); end
        resetn = 1'b0;
        #1;
        checks++; if (load_stall !== 1'b0 || count !== 3'd0 || mem_w_en !== 1'b0) begin errors++; $display("FAIL rw_async: got %0b/%0d/%0b expected 0/0/0", load_stall, count, mem_w_en); end
        tick();
        resetn = 1'b1; tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
        checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rw_no_valid_a: got %0b expected 0", load_valid); end
        tick();
        checks++; if (load_valid !== 1'b0 || count !== 3'd0 || mem_r_en2 !== 1'b0) begin errors++; $display("FAIL rw_after: got %0b/%0d/%0b expected 0/0/0", load_valid, count, mem_r_en2); end
    endtask

    initial begin
        test_reset();
        test_store_full();
        test_forward();
        test_miss();
        test_store_and_load();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
